rom_loader: RTL

//  Boot-time initiator for the instruction ROM's write port. It accepts a byte stream over a

---
 rtl/rom_loader_pkg.sv | 26 ++
 rtl/rom_loader_if.sv | 22 ++
 rtl/rom_loader_pack.sv | 45 ++++
 rtl/rom_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types and widths for the boot-time ROM loader.
// Optional checksum support is enabled by defining ROM_LOADER_CHKSUM_EN.
package rom_loader_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int DATA_W      = 32;
    localparam int COUNT_W     = 16;

    typedef enum logic [3:0] {
        RL_IDLE,
        RL_LEN0,
        RL_LEN1,
        RL_DATA,
        RL_WRITE,
        RL_FIN,
        RL_CHK,
        RL_DONE,
        RL_ERR
    } rl_state_e;

    // The loader is ready for a stream byte only in the states that consume one.
    function automatic logic rl_accepts_byte(input rl_state_e s);
        return (s == RL_LEN0) || (s == RL_LEN1) || (s == RL_DATA) || (s == RL_CHK);
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream and ROM write-port signals for the loader.
// The loader uses the slave modport; the byte source / ROM side uses master.
import rom_loader_pkg::*;

interface rom_loader_if;
    logic [7:0]             byte_i;
    logic                   byte_valid_i;
    logic                   byte_ready_o;
    logic [INST_ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0]      wdata_o;
    logic                   winst_en_o;

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, waddr_o, wdata_o, winst_en_o
    );

    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, waddr_o, wdata_o, winst_en_o
    );
endinterface

// File: rtl/rom_loader_pack.sv
// 8-to-32 little-endian byte assembler. The first byte loaded ends up in
// word_o[7:0]; word_valid_o pulses in the cycle the fourth byte is loaded.
import rom_loader_pkg::*;

module rom_loader_pack (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;

    // Next-state: shift new bytes in from the top so byte 0 lands in the low lane.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = 2'd0;
            word_d = '0;
        end else if (load_i) begin
            idx_d  = idx_q + 2'd1;
            word_d = {byte_i, word_q[DATA_W-1:8]};
        end
    end

    // Byte index and assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = load_i && (idx_q == 2'd3);

endmodule

// File: rtl/rom_loader.sv
// Boot-time loader: reads a length header and a little-endian word image from a
// byte stream, writes it to consecutive ROM word addresses and releases the core
// reset when done. Define ROM_LOADER_CHKSUM_EN to require a trailing XOR byte.
import rom_loader_pkg::*;

module rom_loader #(
    parameter logic [INST_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                     MAX_WORDS = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    rom_loader_if.slave  bus,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         cpu_rst_n_o
);

    rl_state_e              state_q;
    logic [7:0]             len_lo_q;
    logic [COUNT_W-1:0]     rem_q;
    logic [INST_ADDR_W-1:0] waddr_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   cpu_rst_n_q;
`ifdef ROM_LOADER_CHKSUM_EN
    logic [7:0]             chk_q;
`endif

    logic                   ready;
    logic                   accept;
    logic                   start_ok;
    logic [COUNT_W-1:0]     len_full;
    logic [DATA_W-1:0]      word;
    logic                   word_valid;

    assign ready    = rl_accepts_byte(state_q);
    assign accept   = bus.byte_valid_i && ready;
    assign start_ok = start_i && ((state_q == RL_IDLE) || (state_q == RL_DONE) || (state_q == RL_ERR));
    assign len_full = {bus.byte_i, len_lo_q};

    rom_loader_pack u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_ok),
        .load_i       (accept && (state_q == RL_DATA)),
        .byte_i       (bus.byte_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Load sequencer with its address, word-count and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RL_IDLE;
            len_lo_q    <= 8'd0;
            rem_q       <= '0;
            waddr_q     <= BASE_ADDR;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef ROM_LOADER_CHKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            case (state_q)
                RL_IDLE, RL_DONE, RL_ERR: begin
                    if (start_ok) begin
                        state_q     <= RL_LEN0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                        waddr_q     <= BASE_ADDR;
`ifdef ROM_LOADER_CHKSUM_EN
                        chk_q       <= 8'd0;
`endif
                    end
                end
                RL_LEN0: begin
                    if (accept) begin
                        len_lo_q <= bus.byte_i;
                        state_q  <= RL_LEN1;
                    end
                end
                RL_LEN1: begin
                    if (accept) begin
                        if (len_full == '0) begin
                            state_q <= RL_FIN;
                        end else if (32'(len_full) > 32'(MAX_WORDS)) begin
                            state_q <= RL_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            rem_q   <= len_full;
                            state_q <= RL_DATA;
                        end
                    end
                end
                RL_DATA: begin
`ifdef ROM_LOADER_CHKSUM_EN
                    if (accept) begin
                        chk_q <= chk_q ^ bus.byte_i;
                    end
`endif
                    if (word_valid) begin
                        state_q <= RL_WRITE;
                    end
                end
                RL_WRITE: begin
                    waddr_q <= waddr_q + 32'd4;
                    rem_q   <= rem_q - 1'b1;
                    state_q <= (rem_q == 1) ? RL_FIN : RL_DATA;
                end
                RL_FIN: begin
`ifdef ROM_LOADER_CHKSUM_EN
                    state_q     <= RL_CHK;
`else
                    state_q     <= RL_DONE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    cpu_rst_n_q <= 1'b1;
`endif
                end
`ifdef ROM_LOADER_CHKSUM_EN
                RL_CHK: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (bus.byte_i == chk_q) begin
                            state_q     <= RL_DONE;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            state_q <= RL_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= RL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready_o = ready;
    assign bus.winst_en_o   = (state_q == RL_WRITE);
    assign bus.waddr_o      = waddr_q;
    assign bus.wdata_o      = word;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign cpu_rst_n_o      = cpu_rst_n_q;

endmodule
